// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
package fetch_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    // Entry layout at the default 64-bit PC width. The queue keeps PC and
    // instruction in separate arrays so its PC width can follow the instance parameter N.
    typedef struct packed {
        logic [63:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Modulo-DEPTH pointer: wraps DEPTH-1 -> 0 on inc, clears on reset or clear.
// Latency 1 cycle; clear has priority over inc; no backpressure of its own.
module fq_ptr #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {PC, instr} between fetch and decode; flushed on taken branch.
// Push visible at head 1 cycle later, no bypass; push_ready_F is registered-only (count != DEPTH).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int N     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid_F,
    output logic                       push_ready_F,
    input  logic [N-1:0]               push_pc_F,
    input  logic [INSTR_W-1:0]         push_instr_F,
    output logic                       pop_valid_D,
    input  logic                       pop_ready_D,
    output logic [N-1:0]               pop_pc_D,
    output logic [INSTR_W-1:0]         pop_instr_D,
    input  logic                       flush_F,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]       pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [CW-1:0]      count_q;
    logic               push_fire;
    logic               pop_fire;

    assign push_ready_F = (count_q != CW'(DEPTH));
    assign pop_valid_D  = (count_q != '0);
    assign count        = count_q;

    // A flush or reset in the same cycle cancels both handshakes.
    assign push_fire = push_valid_F && push_ready_F && !flush_F && !reset;
    assign pop_fire  = pop_valid_D  && pop_ready_D  && !flush_F && !reset;

    fq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_head (
        .clk   (clk),
        .reset (reset),
        .clear (flush_F),
        .inc   (pop_fire),
        .ptr   (head)
    );

    fq_ptr #(.DEPTH(DEPTH), .AW(AW)) u_tail (
        .clk   (clk),
        .reset (reset),
        .clear (flush_F),
        .inc   (push_fire),
        .ptr   (tail)
    );

    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[tail]    <= push_pc_F;
            instr_mem[tail] <= push_instr_F;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_F) begin
            count_q <= '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_pc_D    = pop_valid_D ? pc_mem[head]    : '0;
    assign pop_instr_D = pop_valid_D ? instr_mem[head] : NOP_INSTR;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed test of fetch_queue: fill, refuse when full, wrap, steady streaming, flush, reset.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid_F;
    logic        push_ready_F;
    logic [63:0] push_pc_F;
    logic [31:0] push_instr_F;
    logic        pop_valid_D;
    logic        pop_ready_D;
    logic [63:0] pop_pc_D;
    logic [31:0] pop_instr_D;
    logic        flush_F;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.N(64), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .push_valid_F (push_valid_F),
        .push_ready_F (push_ready_F),
        .push_pc_F    (push_pc_F),
        .push_instr_F (push_instr_F),
        .pop_valid_D  (pop_valid_D),
        .pop_ready_D  (pop_ready_D),
        .pop_pc_D     (pop_pc_D),
        .pop_instr_D  (pop_instr_D),
        .flush_F      (flush_F),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return {16'hA5A5, pc[15:0]};
    endfunction

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] pc);
        push_valid_F = 1'b1;
        push_pc_F    = pc;
        push_instr_F = instr_of(pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        int nxt;
        int cyc;

        reset        = 1'b1;
        push_valid_F = 1'b0;
        push_pc_F    = '0;
        push_instr_F = '0;
        pop_ready_D  = 1'b0;
        flush_F      = 1'b0;
        repeat (2) tick();

        expect_eq("rst_count", 64'(count), 0);
        expect_eq("rst_pop_valid", 64'(pop_valid_D), 0);
        expect_eq("rst_push_ready", 64'(push_ready_F), 1);
        expect_eq("rst_instr_nop", 64'(pop_instr_D), 64'hD503201F);
        expect_eq("rst_pc_zero", pop_pc_D, 0);
        reset = 1'b0;
        tick();
        expect_eq("idle_count", 64'(count), 0);

        // Fill to DEPTH without popping
        for (int i = 0; i < 4; i++) begin
            offer(64'(4 * i));
            tick();
            expect_eq("fill_count", 64'(count), 64'(i + 1));
            expect_eq("fill_head_pc", pop_pc_D, 0);
        end
        expect_eq("full_push_ready", 64'(push_ready_F), 0);
        offer(64'h10);
        tick();
        expect_eq("refuse_count", 64'(count), 4);
        expect_eq("refuse_head_pc", pop_pc_D, 0);
        expect_eq("refuse_head_instr", 64'(pop_instr_D), 64'(instr_of(0)));

        // Drain while pushing 0x10..0x1C; pointers wrap past slot 3
        pop_ready_D = 1'b1;
        got = 0;
        nxt = 4;
        cyc = 0;
        while (got < 8 && cyc < 40) begin
            push_valid_F = (nxt < 8);
            push_pc_F    = 64'(4 * nxt);
            push_instr_F = instr_of(64'(4 * nxt));
            if (pop_valid_D) begin
                expect_eq("drain_pc", pop_pc_D, 64'(4 * got));
                expect_eq("drain_instr", 64'(pop_instr_D), 64'(instr_of(64'(4 * got))));
                got++;
            end
            if (push_valid_F && push_ready_F) nxt++;
            tick();
            cyc++;
        end
        expect_eq("drain_popped", 64'(got), 8);
        push_valid_F = 1'b0;
        pop_ready_D  = 1'b0;
        expect_eq("drain_count", 64'(count), 0);
        expect_eq("drain_pop_valid", 64'(pop_valid_D), 0);

        // Steady state with two entries resident
        offer(64'h200);
        tick();
        offer(64'h204);
        tick();
        for (int i = 0; i < 10; i++) begin
            offer(64'(32'h208 + 4 * i));
            pop_ready_D = 1'b1;
            expect_eq("stream_pc", pop_pc_D, 64'(32'h200 + 4 * i));
            tick();
            expect_eq("stream_count", 64'(count), 2);
        end
        push_valid_F = 1'b0;
        pop_ready_D  = 1'b0;

        flush_F = 1'b1;
        tick();
        flush_F = 1'b0;
        expect_eq("flush1_count", 64'(count), 0);

        // Flush wins over a simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            offer(64'(32'h30 + 4 * i));
            tick();
        end
        expect_eq("pre_flush_count", 64'(count), 3);
        offer(64'h40);
        pop_ready_D = 1'b1;
        flush_F     = 1'b1;
        tick();
        flush_F      = 1'b0;
        push_valid_F = 1'b0;
        pop_ready_D  = 1'b0;
        expect_eq("flush_count", 64'(count), 0);
        expect_eq("flush_pop_valid", 64'(pop_valid_D), 0);
        expect_eq("flush_push_ready", 64'(push_ready_F), 1);
        expect_eq("flush_instr_nop", 64'(pop_instr_D), 64'hD503201F);
        expect_eq("flush_pc_zero", pop_pc_D, 0);
        offer(64'h80);
        tick();
        push_valid_F = 1'b0;
        expect_eq("post_flush_valid", 64'(pop_valid_D), 1);
        expect_eq("post_flush_pc", pop_pc_D, 64'h80);
        expect_eq("post_flush_count", 64'(count), 1);

        // Reset with 3 entries buffered and a push pending
        offer(64'h84);
        tick();
        offer(64'h88);
        tick();
        expect_eq("pre_rst_count", 64'(count), 3);
        offer(64'h99);
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        push_valid_F = 1'b0;
        expect_eq("midrst_count", 64'(count), 0);
        expect_eq("midrst_pop_valid", 64'(pop_valid_D), 0);
        expect_eq("midrst_pc_zero", pop_pc_D, 0);
        expect_eq("midrst_push_ready", 64'(push_ready_F), 1);
        offer(64'h100);
        tick();
        push_valid_F = 1'b0;
        expect_eq("post_rst_pc", pop_pc_D, 64'h100);
        expect_eq("post_rst_count", 64'(count), 1);
        expect_eq("post_rst_slot0", dut.pc_mem[0], 64'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch buffer between the fetch stage and the decode stage. Holds up to DEPTH fetched {PC, instruction} pairs so fetch can keep streaming while decode stalls. Supplies decode the oldest entry in program order. Discards all buffered entries on a taken branch, so no wrong-path instruction reaches decode.

## Interface

Parameters:
- N, 64, PC width in bits.
- DEPTH, 4, number of entries; power of two, ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- push_valid_F  input  1  fetch offers an entry this cycle.
- push_ready_F  output  1  queue accepts an entry this cycle.
- push_pc_F  input  N  PC of the offered instruction.
- push_instr_F  input  32  offered instruction word.
- pop_valid_D  output  1  head entry is valid.
- pop_ready_D  input  1  decode consumes the head this cycle.
- pop_pc_D  output  N  PC of the head entry.
- pop_instr_D  output  32  instruction word of the head entry.
- flush_F  input  1  taken branch (PCSrc); discard all entries.
- count  output  $clog2(DEPTH+1)  current occupancy.

## Operation

- Circular buffer of DEPTH entries, with head (read) and tail (write) pointers, each $clog2(DEPTH) bits.
- Occupancy is tracked in a separate counter (count), so full and empty need no pointer comparison.
- Push fires when push_valid_F && push_ready_F:
  - entry written at tail;
  - tail increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- Pop fires when pop_valid_D && pop_ready_D: head increments modulo DEPTH.
- count update per cycle: +1 on push only, −1 on pop only, unchanged when both fire or neither fires.
- push_ready_F = (count != DEPTH). It depends on registered state only; there is no combinational path from pop_ready_D.
- pop_valid_D = (count != 0).
- When the queue is not empty, pop_pc_D and pop_instr_D read the head entry combinationally.
- When the queue is empty, the outputs are forced to pop_pc_D = 0 and pop_instr_D = NOP (32'hD503201F).
- Flush: at the edge where flush_F = 1, head, tail and count all go to 0. Any push or pop presented in that same cycle is ignored: nothing is written, and the pop is not counted as consumed.
- Reset:
  - same state effect as flush;
  - highest priority, above flush, push and pop;
  - storage array contents are not cleared.
- Reset mid-operation: all buffered entries are lost. The first push after reset deasserts lands in slot 0.
- Output values during and after reset, until the first push: push_ready_F = 1, pop_valid_D = 0, count = 0, pop_pc_D = 0, pop_instr_D = NOP.
- Push while full: push_ready_F = 0, the entry is not stored, and fetch must hold its request.
- Pop while empty: no effect.

## Timing

- Push-to-visible latency is 1 cycle. An entry pushed at edge t drives pop_valid_D = 1 in the cycle after t.
- There is no same-cycle bypass from push to pop when the queue is empty.
- Sustained throughput is 1 push and 1 pop per cycle when 0 < count < DEPTH.
- Simultaneous push and pop when full: push_ready_F is 0, so only the pop fires. push_ready_F rises in the next cycle.
- Simultaneous push and pop with count = 1: both fire; count stays 1 and the head advances to the new entry.
- After a flush edge, pop_valid_D = 0 in the next cycle and push_ready_F = 1. The first correct-path push can then land.

## Structure

- Shared package fetch_pkg contains:
  - INSTR_W = 32;
  - NOP_INSTR = 32'hD503201F;
  - typedef fetch_entry_t: packed {pc, instr}, with the PC width taken from the parameter at the use site via a parameterised struct wrapper, or kept as separate arrays if that is not supported.
- One sub-module, fq_ptr: a modulo-DEPTH pointer register with synchronous clear and an increment enable. It is instantiated twice, once for head and once for tail.
- The storage array and the count logic live in fetch_queue itself.

## Test plan

- Reset, then idle → count = 0, pop_valid_D = 0, push_ready_F = 1, pop_instr_D = 32'hD503201F, pop_pc_D = 0.
- Push PCs 0x0, 0x4, 0x8, 0xC with pop_ready_D = 0 → count = 4 and push_ready_F = 0. A fifth push of PC 0x10 is refused. Head reads PC 0x0 throughout.
- From full, pop continuously while pushing 0x10, 0x14, 0x18, 0x1C → pops come out in order 0x0 … 0x1C, the pointers wrap past slot 3, and there are no duplicates or drops.
- Hold count = 2 and push and pop every cycle for 10 cycles → count stays 2 and the outputs are in strict PC order.
- Fill 3 entries, then assert flush_F together with a push of PC 0x40 and pop_ready_D = 1 → next cycle count = 0 and pop_valid_D = 0. A following push of 0x80 appears as head one cycle later.
- Assert reset with 3 entries buffered while push_valid_F = 1 → next cycle count = 0, with no entry stored. A push of 0x100 afterwards is written to slot 0 and appears at the head.
